edp_slice_gen: RTL
==================

// Module: edp_slice_gen
// PURPOSE
//  Parametrised EBOX data-path slice: AR/ARX/BR/BRX/MQ, one AD adder, fast-memory (FM) bank with parity.
//  Slices chain by carry/group carry-gen/prop to build a full word; EBUS drive and diag read are included.
//  Adds over the fixed 6-bit slice: width/FM-depth params, synchronous FM read, sticky parity error, MQ shift modes.
// PARAMETERS
//  WIDTH      6   bits per slice (>=2)
//  FM_BLOCKS  8   FM blocks (power of 2); 16 words per block
//  TOP_SLICE  0   1 = slice holds word MSB; enables ad_overflow_h
// PORTS
//  clk_edp_h         in   1        single data-path clock; all state changes on rising edge
//  reset_l           in   1        asynchronous, active-low reset
//  ar_sel            in   3        AR source: 0 hold,1 AD,2 sh_h,3 cache_data_h,4 FM rd,5 vma_pc_h,6 zero,7 AD<<1
//  arx_sel           in   2        ARX source: 0 hold,1 AD,2 MQ,3 cache_data_h
//  br_load_h/brx_load_h in 1 ea    BR<=AR, BRX<=ARX
//  mq_sel            in   2        0 hold,1 shr (msb<=mq_in_h),2 shl (lsb<=mq_in_h),3 MQ<=AD
//  mq_in_h           in   1        MQ shift-in bit from neighbour slice
//  ar_shin_h         in   1        LSB shifted in for ar_sel=7
//  ada_sel/adb_sel   in   2 ea     A:0 AR,1 ARX,2 MQ,3 vma_pc_h; B:0 BR,1 BRX,2 AR<<1(ar_shin_h),3 FM rd
//  ada_dis_h         in   1        force A=0
//  ad_op             in   3        0 A+B+cin,1 A+~B+cin,2 A&B,3 A|B,4 A^B,5 ~A,6 A,7 B
//  ad_cry_in_h       in   1        carry in from lower slice
//  sh_h, cache_data_h, vma_pc_h  in WIDTH ea  external sources
//  fm_block/fm_adr   in   log2(FM_BLOCKS)/4  FM address
//  fm_write_h        in   1        write AR + parity at address
//  fm_par_inv_h      in   1        diag: invert stored parity on this write
//  fm_chk_en_h       in   1        enable parity check of FM read register
//  fm_par_clr_h      in   1        clear sticky parity error
//  ad_to_ebus_h      in   1        drive AD on EBUS
//  diag_read_h       in   1        drive diag_sel register on EBUS
//  diag_sel          in   3        0 AR,1 ARX,2 BR,3 BRX,4 MQ,5 FM rd,6/7 zero
//  ar/arx/br/brx/mq_h  out WIDTH ea  register outputs
//  ad_h              out  WIDTH    adder result (comb)
//  ad_cry_out_h      out  1        carry out of slice MSB
//  ad_cg_h/ad_cp_h   out  1 ea     group generate/propagate
//  ad_zero_l         out  1        low when ad_h==0
//  ad_overflow_h     out  1        cry into MSB ^ cry out; 0 if TOP_SLICE=0
//  ebus_d_h          out  WIDTH    EBUS data (0 when not driving)
//  fm_parity_h       out  1        stored parity bit of FM read register
//  fm_par_err_h      out  1        sticky FM parity error
// BEHAVIOUR
//  Reset (async, reset_l=0): AR,ARX,BR,BRX,MQ,FM read data=0; all FM words=0, parity=1; fm_par_err_h=0.
//  AD purely combinational from current regs; every register update on the edge after selects are presented.
//  All loads sample pre-edge values: br_load_h with ar_sel!=0 gives BR=old AR; arx_sel=2 with mq shift gives old MQ.
//  Ops 0/1: cg=carry out with cin=0, cp=&(A^B') (B'=B or ~B); ops 2-7: cry_out=cg=cp=0.
//  FM: parity odd (^{data,p}=1). Write at edge: word<=AR, p<=~^AR ^ fm_par_inv_h.
//   Read is synchronous: read register <= addressed word every edge; visible to AR/ADB/diag next cycle.
//   Same-address read+write in one edge: read register gets old word (read-before-write).
//  Parity check: fm_chk_en_h=1 and ^{rd_data,rd_p}==0 -> fm_par_err_h set next edge; held until fm_par_clr_h
//   or reset; clr and new error same edge -> set wins.
//  EBUS: ad_to_ebus_h priority over diag_read_h; neither -> 0.
//  Reset mid-op: all state clears immediately; outputs follow next combinational evaluation.
// TESTING (WIDTH=6)
//  AR=0x3F,BR=0x01,op0,cin=0 -> ad_h=0x00, cry_out=1, cg=1, ad_zero_l=0; AR<=AD gives 0.
//  AR=5,BR=3,op1,cin=1 -> ad_h=0x02, cry_out=1; TOP_SLICE=1, AR=0x1F,BR=1,op0 -> overflow=1.
//  write AR=0x2A to blk3/adr5; next cycle read -> rd data 0x2A, fm_parity_h=0; same-edge rewrite 0x15 -> old 0x2A.
//  write with fm_par_inv_h=1, read with chk_en -> fm_par_err_h=1 after 1 edge, stays until clr pulse.
//  MQ=0, mq_in_h=1, mq_sel=1 two edges -> 0x20 then 0x30; mq_sel=2 from 0x30, in=0 -> 0x20.
//  ad_to_ebus+diag_read both 1 -> ebus=AD; assert reset_l mid-load -> all regs 0 same cycle.

Source files
------------

// File: rtl/edp_slice_gen.sv
// One EBOX data-path slice: AR/ARX/BR/BRX/MQ registers, AD adder with group carry,
// fast-memory bank with odd parity and a sticky parity error, EBUS drive and diag read.
module edp_slice_gen #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned FM_BLOCKS = 8,
  parameter int unsigned TOP_SLICE = 0
) (
  input  logic                 clk_edp_h,
  input  logic                 reset_l,
  input  logic [2:0]           ar_sel,
  input  logic [1:0]           arx_sel,
  input  logic                 br_load_h,
  input  logic                 brx_load_h,
  input  logic [1:0]           mq_sel,
  input  logic                 mq_in_h,
  input  logic                 ar_shin_h,
  input  logic [1:0]           ada_sel,
  input  logic [1:0]           adb_sel,
  input  logic                 ada_dis_h,
  input  logic [2:0]           ad_op,
  input  logic                 ad_cry_in_h,
  input  logic [WIDTH-1:0]     sh_h,
  input  logic [WIDTH-1:0]     cache_data_h,
  input  logic [WIDTH-1:0]     vma_pc_h,
  input  logic [((FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1)-1:0] fm_block,
  input  logic [3:0]           fm_adr,
  input  logic                 fm_write_h,
  input  logic                 fm_par_inv_h,
  input  logic                 fm_chk_en_h,
  input  logic                 fm_par_clr_h,
  input  logic                 ad_to_ebus_h,
  input  logic                 diag_read_h,
  input  logic [2:0]           diag_sel,
  output logic [WIDTH-1:0]     ar_h,
  output logic [WIDTH-1:0]     arx_h,
  output logic [WIDTH-1:0]     br_h,
  output logic [WIDTH-1:0]     brx_h,
  output logic [WIDTH-1:0]     mq_h,
  output logic [WIDTH-1:0]     ad_h,
  output logic                 ad_cry_out_h,
  output logic                 ad_cg_h,
  output logic                 ad_cp_h,
  output logic                 ad_zero_l,
  output logic                 ad_overflow_h,
  output logic [WIDTH-1:0]     ebus_d_h,
  output logic                 fm_parity_h,
  output logic                 fm_par_err_h
);

  localparam int unsigned FM_BW    = (FM_BLOCKS > 1) ? $clog2(FM_BLOCKS) : 1;
  localparam int unsigned FM_AW    = FM_BW + 4;
  localparam int unsigned FM_WORDS = FM_BLOCKS * 16;

  logic [WIDTH-1:0] r_ar, r_arx, r_br, r_brx, r_mq;
  logic [WIDTH-1:0] r_fm_rd;
  logic             r_fm_rd_p;
  logic             r_par_err;
  logic [WIDTH-1:0] r_fm_data [FM_WORDS];
  logic             r_fm_par  [FM_WORDS];

  logic [WIDTH-1:0] w_ada, w_adb, w_bx, w_ad, w_diag;
  logic [WIDTH:0]   w_sum, w_gsum;
  logic             w_arith, w_cin_msb;
  logic [FM_AW-1:0] w_fm_addr;

  assign w_fm_addr = {fm_block, fm_adr};

  // Adder operand selection; B is inverted for the subtract-style op
  always_comb begin
    w_ada = '0;
    w_adb = '0;
    case (ada_sel)
      2'd0:    w_ada = r_ar;
      2'd1:    w_ada = r_arx;
      2'd2:    w_ada = r_mq;
      default: w_ada = vma_pc_h;
    endcase
    if (ada_dis_h) w_ada = '0;
    case (adb_sel)
      2'd0:    w_adb = r_br;
      2'd1:    w_adb = r_brx;
      2'd2:    w_adb = {r_ar[WIDTH-2:0], ar_shin_h};
      default: w_adb = r_fm_rd;
    endcase
  end

  assign w_bx    = (ad_op == 3'd1) ? ~w_adb : w_adb;
  assign w_arith = (ad_op == 3'd0) || (ad_op == 3'd1);
  assign w_sum   = {1'b0, w_ada} + {1'b0, w_bx} + (WIDTH+1)'(ad_cry_in_h);
  assign w_gsum  = {1'b0, w_ada} + {1'b0, w_bx};
  assign w_cin_msb = w_ada[WIDTH-1] ^ w_bx[WIDTH-1] ^ w_sum[WIDTH-1];

  always_comb begin
    w_ad = '0;
    case (ad_op)
      3'd0, 3'd1: w_ad = w_sum[WIDTH-1:0];
      3'd2:       w_ad = w_ada & w_adb;
      3'd3:       w_ad = w_ada | w_adb;
      3'd4:       w_ad = w_ada ^ w_adb;
      3'd5:       w_ad = ~w_ada;
      3'd6:       w_ad = w_ada;
      default:    w_ad = w_adb;
    endcase
  end

  assign ad_h          = w_ad;
  assign ad_cry_out_h  = w_arith & w_sum[WIDTH];
  assign ad_cg_h       = w_arith & w_gsum[WIDTH];
  assign ad_cp_h       = w_arith & (&(w_ada ^ w_bx));
  assign ad_zero_l     = |w_ad;
  assign ad_overflow_h = (TOP_SLICE != 32'd0) & w_arith & (w_cin_msb ^ w_sum[WIDTH]);

  // Data-path registers; every source samples pre-edge values
  always_ff @(posedge clk_edp_h or negedge reset_l) begin
    if (!reset_l) begin
      r_ar  <= '0;
      r_arx <= '0;
      r_br  <= '0;
      r_brx <= '0;
      r_mq  <= '0;
    end else begin
      case (ar_sel)
        3'd0:    r_ar <= r_ar;
        3'd1:    r_ar <= w_ad;
        3'd2:    r_ar <= sh_h;
        3'd3:    r_ar <= cache_data_h;
        3'd4:    r_ar <= r_fm_rd;
        3'd5:    r_ar <= vma_pc_h;
        3'd6:    r_ar <= '0;
        default: r_ar <= {w_ad[WIDTH-2:0], ar_shin_h};
      endcase
      case (arx_sel)
        2'd0:    r_arx <= r_arx;
        2'd1:    r_arx <= w_ad;
        2'd2:    r_arx <= r_mq;
        default: r_arx <= cache_data_h;
      endcase
      if (br_load_h)  r_br  <= r_ar;
      if (brx_load_h) r_brx <= r_arx;
      case (mq_sel)
        2'd0:    r_mq <= r_mq;
        2'd1:    r_mq <= {mq_in_h, r_mq[WIDTH-1:1]};
        2'd2:    r_mq <= {r_mq[WIDTH-2:0], mq_in_h};
        default: r_mq <= w_ad;
      endcase
    end
  end

  // FM array: words reset to zero with good (odd) parity
  always_ff @(posedge clk_edp_h or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < int'(FM_WORDS); i++) begin
        r_fm_data[i] <= '0;
        r_fm_par[i]  <= 1'b1;
      end
    end else if (fm_write_h) begin
      r_fm_data[w_fm_addr] <= r_ar;
      r_fm_par[w_fm_addr]  <= ~(^r_ar) ^ fm_par_inv_h;
    end
  end

  // Synchronous read register (read-before-write) and sticky parity error
  always_ff @(posedge clk_edp_h or negedge reset_l) begin
    if (!reset_l) begin
      r_fm_rd   <= '0;
      r_fm_rd_p <= 1'b1;
      r_par_err <= 1'b0;
    end else begin
      r_fm_rd   <= r_fm_data[w_fm_addr];
      r_fm_rd_p <= r_fm_par[w_fm_addr];
      if (fm_chk_en_h && !(^{r_fm_rd, r_fm_rd_p})) r_par_err <= 1'b1;
      else if (fm_par_clr_h)                        r_par_err <= 1'b0;
    end
  end

  always_comb begin
    w_diag = '0;
    case (diag_sel)
      3'd0:    w_diag = r_ar;
      3'd1:    w_diag = r_arx;
      3'd2:    w_diag = r_br;
      3'd3:    w_diag = r_brx;
      3'd4:    w_diag = r_mq;
      3'd5:    w_diag = r_fm_rd;
      default: w_diag = '0;
    endcase
  end

  assign ebus_d_h     = ad_to_ebus_h ? w_ad : (diag_read_h ? w_diag : '0);
  assign ar_h         = r_ar;
  assign arx_h        = r_arx;
  assign br_h         = r_br;
  assign brx_h        = r_brx;
  assign mq_h         = r_mq;
  assign fm_parity_h  = r_fm_rd_p;
  assign fm_par_err_h = r_par_err;

endmodule
